// File: rtl/instr_loader_pkg.sv
// Shared constants and FSM encoding for the program loader.
// The debug unit and the testbenches reuse these definitions.
package instr_loader_pkg;

  localparam logic [7:0]  CMD_LOAD       = 8'h4C;
  localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone,
    StError
  } state_e;

endpackage

// File: rtl/instr_loader_if.sv
// UART byte stream into the loader and the instruction-memory write bus out of it.
interface instr_loader_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic [7:0]            i_rx_data;
  logic                  i_rx_done;
  logic [DATA_WIDTH-1:0] o_instruccion;
  logic [DATA_WIDTH-1:0] o_address;
  logic                  o_loading;

  modport slave (
    input  i_rx_data,
    input  i_rx_done,
    output o_instruccion,
    output o_address,
    output o_loading
  );

  modport master (
    output i_rx_data,
    output i_rx_done,
    input  o_instruccion,
    input  o_address,
    input  o_loading
  );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words.
// o_word shows the word that includes the byte being accepted this cycle.
module instr_loader_byte_packer
  import instr_loader_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [31:0] r_shift;
  logic [1:0]  r_count;
  logic        w_take;

  assign w_take       = i_enable && i_byte_valid;
  assign o_word       = {r_shift[23:0], i_byte};
  assign o_word_valid = w_take && (r_count == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (w_take) begin
      r_shift <= o_word;
      r_count <= r_count + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a program from the debug UART byte stream into instruction memory,
// one 32-bit word per write strobe, until HALT or memory full.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned ADDR_INCR  = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  instr_loader_if.slave              bus,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error,
  output logic [$clog2(MEM_DEPTH):0] o_word_count
);

  localparam int unsigned CW = $clog2(MEM_DEPTH) + 1;

  state_e                r_state;
  state_e                w_next;
  logic                  w_clear;
  logic                  w_pack_en;
  logic [31:0]           w_word;
  logic                  w_word_valid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_address;
  logic                  r_loading;
  logic                  r_error;
  logic [CW-1:0]         r_word_count;

  // Packer stays enabled in WRITE so a byte landing there starts the next word.
  assign w_pack_en = (r_state == StRecv) || (r_state == StWrite);

  instr_loader_byte_packer u_byte_packer (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (w_clear),
    .i_enable     (w_pack_en),
    .i_byte_valid (bus.i_rx_done),
    .i_byte       (bus.i_rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.i_rx_done && (bus.i_rx_data == CMD_LOAD)) begin
          w_next  = StRecv;
          w_clear = 1'b1;
        end
      end
      StRecv: begin
        o_busy = 1'b1;
        if (w_word_valid) begin
          w_next = StWrite;
        end
      end
      StWrite: begin
        o_busy = 1'b1;
        // HALT is checked first so a HALT in the last slot completes cleanly.
        if (r_instr == HALT_WORD) begin
          w_next = StDone;
        end else if (r_word_count == CW'(MEM_DEPTH)) begin
          w_next = StError;
        end else begin
          w_next = StRecv;
        end
      end
      StDone: begin
        o_done = 1'b1;
        w_next = StIdle;
      end
      StError: begin
        w_next = StIdle;
      end
      default: begin
        w_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_instr      <= '0;
      r_address    <= '0;
      r_loading    <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_loading <= 1'b0;
      if (w_clear) begin
        r_address    <= '0;
        r_error      <= 1'b0;
        r_word_count <= '0;
      end
      if ((r_state == StRecv) && w_word_valid) begin
        r_loading    <= 1'b1;
        r_instr      <= w_word;
        r_address    <= DATA_WIDTH'(r_word_count) * DATA_WIDTH'(ADDR_INCR);
        r_word_count <= r_word_count + CW'(1);
      end
      if ((r_state == StWrite) && (w_next == StError)) begin
        r_error <= 1'b1;
      end
    end
  end

  assign bus.o_instruccion = r_instr;
  assign bus.o_address     = r_address;
  assign bus.o_loading     = r_loading;
  assign o_error           = r_error;
  assign o_word_count      = r_word_count;

endmodule

// File: tb/tb_instr_loader.sv
// Randomised sessions on a full-size loader and a 4-word loader, checked against
// a byte-level model of the load protocol (writes, timing, done/error, word count).
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam int unsigned DEPTH_A = 256;
  localparam int unsigned DEPTH_B = 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy_a, done_a, err_a;
  logic       busy_b, done_b, err_b;
  logic [8:0] wc_a;
  logic [2:0] wc_b;

  always #5 clk = ~clk;

  instr_loader_if #(.DATA_WIDTH(32)) bus_a ();
  instr_loader_if #(.DATA_WIDTH(32)) bus_b ();

  instr_loader #(.DATA_WIDTH(32), .MEM_DEPTH(DEPTH_A), .ADDR_INCR(4)) dut_a (
    .i_clock      (clk),
    .i_reset      (rst),
    .bus          (bus_a),
    .o_busy       (busy_a),
    .o_done       (done_a),
    .o_error      (err_a),
    .o_word_count (wc_a)
  );

  instr_loader #(.DATA_WIDTH(32), .MEM_DEPTH(DEPTH_B), .ADDR_INCR(4)) dut_b (
    .i_clock      (clk),
    .i_reset      (rst),
    .bus          (bus_b),
    .o_busy       (busy_b),
    .o_done       (done_b),
    .o_error      (err_b),
    .o_word_count (wc_b)
  );

  int         cyc = 0;
  wr_t        act_a[$];
  wr_t        act_b[$];
  int         done_cnt[2];
  int         done_cyc[2];

  int         n_checks = 0;
  int         n_errors = 0;
  int         rd_ptr[2];
  int         done_base[2];
  int         m_wc[2];
  int         m_err[2];
  logic [7:0] pend_q[$];
  logic [7:0] st_b[$];
  int         st_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observers: every write strobe and done pulse, stamped with the cycle number.
  always @(negedge clk) begin
    if (bus_a.o_loading) act_a.push_back('{cyc: cyc, addr: bus_a.o_address, data: bus_a.o_instruccion});
    if (bus_b.o_loading) act_b.push_back('{cyc: cyc, addr: bus_b.o_address, data: bus_b.o_instruccion});
    if (done_a) begin done_cnt[0] = done_cnt[0] + 1; done_cyc[0] = cyc; end
    if (done_b) begin done_cnt[1] = done_cnt[1] + 1; done_cyc[1] = cyc; end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left on a negedge so back-to-back strobes are possible.
  task automatic send(input bit sel, input logic [7:0] b, input int gap);
    if (sel) begin bus_b.i_rx_data = b; bus_b.i_rx_done = 1'b1; end
    else     begin bus_a.i_rx_data = b; bus_a.i_rx_done = 1'b1; end
    @(negedge clk);
    st_b.push_back(b);
    st_c.push_back(cyc);
    bus_a.i_rx_done = 1'b0;
    bus_b.i_rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic play(input bit sel, input int gapmax);
    foreach (pend_q[i]) send(sel, pend_q[i], int'($urandom_range(gapmax, 0)));
    pend_q.delete();
    repeat (8) @(negedge clk);
  endtask

  task automatic add_session(input int junk, input int nwords, input bit halt, input bit allow_cmd);
    logic [31:0] w;
    logic [7:0]  b;
    for (int j = 0; j < junk; j++) begin
      b = 8'($urandom);
      if (b == CMD_LOAD) b = 8'h4D;
      pend_q.push_back(b);
    end
    pend_q.push_back(CMD_LOAD);
    for (int k = 0; k < nwords; k++) begin
      w = $urandom;
      if (w == HALT_WORD) w = 32'h1234_5678;
      for (int j = 3; j >= 0; j--) begin
        b = w[j*8 +: 8];
        if (!allow_cmd && b == CMD_LOAD) b = 8'h4D;
        pend_q.push_back(b);
      end
    end
    if (halt) repeat (4) pend_q.push_back(8'hFF);
  endtask

  // Reference: walk the sent bytes through the load protocol and compare.
  task automatic verify(input bit sel, input int depth);
    wr_t         e[$];
    wr_t         a;
    logic [31:0] w;
    int          n;
    int          ndone;
    int          dcyc;
    int          nact;
    bit          active;
    active = 1'b0; n = 0; w = '0; ndone = 0; dcyc = 0;
    for (int i = 0; i < st_b.size(); i++) begin
      if (!active) begin
        if (st_b[i] == CMD_LOAD) begin
          active = 1'b1; n = 0; m_wc[sel] = 0; m_err[sel] = 0;
        end
      end else begin
        w = {w[23:0], st_b[i]};
        n++;
        if (n == 4) begin
          e.push_back('{cyc: st_c[i], addr: 32'(m_wc[sel] * 4), data: w});
          m_wc[sel]++;
          n = 0;
          if (w == HALT_WORD) begin
            active = 1'b0; ndone++; dcyc = st_c[i] + 1;
          end else if (m_wc[sel] == depth) begin
            active = 1'b0; m_err[sel] = 1;
          end
        end
      end
    end
    nact = (sel ? act_b.size() : act_a.size()) - rd_ptr[sel];
    check_eq("write_count", 64'(nact), 64'(e.size()));
    for (int i = 0; i < e.size() && i < nact; i++) begin
      a = sel ? act_b[rd_ptr[1] + i] : act_a[rd_ptr[0] + i];
      check_eq("write_cycle", 64'(a.cyc), 64'(e[i].cyc));
      check_eq("write_addr", 64'(a.addr), 64'(e[i].addr));
      check_eq("write_data", 64'(a.data), 64'(e[i].data));
    end
    check_eq("word_count", 64'(sel ? 32'(wc_b) : 32'(wc_a)), 64'(m_wc[sel]));
    check_eq("error", 64'(sel ? err_b : err_a), 64'(m_err[sel]));
    check_eq("done_pulses", 64'(done_cnt[sel] - done_base[sel]), 64'(ndone));
    if (ndone > 0) check_eq("done_cycle", 64'(done_cyc[sel]), 64'(dcyc));
    check_eq("busy_idle", 64'(sel ? busy_b : busy_a), 64'd0);
    rd_ptr[sel]    = sel ? act_b.size() : act_a.size();
    done_base[sel] = done_cnt[sel];
    st_b.delete();
    st_c.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_wc[s] = 0; m_err[s] = 0; done_base[s] = done_cnt[s];
    end
    st_b.delete();
    st_c.delete();
  endtask

  initial begin
    bus_a.i_rx_data = '0; bus_a.i_rx_done = 1'b0;
    bus_b.i_rx_data = '0; bus_b.i_rx_done = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rd_ptr[s] = 0; done_base[s] = 0; m_wc[s] = 0; m_err[s] = 0; done_cnt[s] = 0; done_cyc[s] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_eq("rst_busy", 64'(busy_a), 64'd0);
    check_eq("rst_done", 64'(done_a), 64'd0);
    check_eq("rst_error", 64'(err_a), 64'd0);
    check_eq("rst_wc", 64'(wc_a), 64'd0);
    check_eq("rst_loading", 64'(bus_a.o_loading), 64'd0);
    check_eq("rst_addr", 64'(bus_a.o_address), 64'd0);
    check_eq("rst_instr", 64'(bus_a.o_instruccion), 64'd0);
    check_eq("rst_error_b", 64'(err_b), 64'd0);

    // Basic program, back to back, so the HALT's first byte lands in WRITE.
    pend_q = '{8'h4C, 8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    play(1'b0, 0);
    if (act_a.size() >= rd_ptr[0] + 2) begin
      check_eq("basic_w0", 64'(act_a[rd_ptr[0]].data), 64'h2001_0005);
      check_eq("basic_a1", 64'(act_a[rd_ptr[0] + 1].addr), 64'd4);
    end
    check_eq("basic_wc", 64'(wc_a), 64'd2);
    verify(1'b0, DEPTH_A);

    // Leading junk byte, then CMD_LOAD appearing as data inside the session.
    pend_q = '{8'h11, 8'h4C, 8'h22, 8'h33, 8'h44, 8'h55, 8'h4C, 8'h01, 8'h02, 8'h03,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
    play(1'b0, 2);
    if (act_a.size() >= rd_ptr[0] + 2) begin
      check_eq("junk_w0", 64'(act_a[rd_ptr[0]].data), 64'h2233_4455);
      check_eq("cmd_as_data", 64'(act_a[rd_ptr[0] + 1].data), 64'h4C01_0203);
    end
    verify(1'b0, DEPTH_A);

    for (int t = 0; t < 20; t++) begin
      add_session(int'($urandom_range(2, 0)), int'($urandom_range(6, 1)), 1'b1, 1'b1);
      play(1'b0, 3);
      verify(1'b0, DEPTH_A);
    end

    // Small memory: five words without HALT overflow it.
    add_session(0, 5, 1'b0, 1'b0);
    play(1'b1, 2);
    check_eq("full_error", 64'(err_b), 64'd1);
    verify(1'b1, DEPTH_B);
    repeat (20) @(negedge clk);
    check_eq("error_sticky", 64'(err_b), 64'd1);

    // HALT as the last word that fits: done, not error.
    add_session(0, 3, 1'b1, 1'b0);
    play(1'b1, 1);
    check_eq("halt_last_err", 64'(err_b), 64'd0);
    verify(1'b1, DEPTH_B);

    for (int t = 0; t < 12; t++) begin
      add_session(int'($urandom_range(1, 0)), int'($urandom_range(6, 0)), 1'b1, 1'b0);
      play(1'b1, int'($urandom_range(3, 0)));
      verify(1'b1, DEPTH_B);
    end

    // Reset in the middle of a word abandons the session.
    rd_ptr[0] = act_a.size();
    pend_q = '{8'h4C, 8'hAA, 8'hBB};
    play(1'b0, 1);
    do_reset();
    repeat (6) @(negedge clk);
    check_eq("midrst_writes", 64'(act_a.size() - rd_ptr[0]), 64'd0);
    check_eq("midrst_busy", 64'(busy_a), 64'd0);
    check_eq("midrst_wc", 64'(wc_a), 64'd0);
    rd_ptr[0] = act_a.size();
    rd_ptr[1] = act_b.size();
    add_session(0, 2, 1'b1, 1'b1);
    play(1'b0, 2);
    verify(1'b0, DEPTH_A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
